sram_rmw_ctrl: RTL
==================

// Module: sram_rmw_ctrl
// PURPOSE
// - Front-end sequencer placed directly upstream of the cache SRAM macro wrapper (sram_cache, TECHNO_CUT=1).
// - Macro has no byte enables; this block turns partial-byte writes into read-modify-write (RMW) sequences.
// - Full writes and reads pass through in one cycle; the SRAM sees only full-word accesses.
// PARAMETERS
// - DATA_WIDTH  64   word width in bits; need not be a multiple of 8.
// - NUM_WORDS   256  SRAM depth in words.
// - AW          $clog2(NUM_WORDS)  address width (derived, localparam).
// - BE_W        (DATA_WIDTH+7)/8   byte-enable width (derived, localparam).
// PORTS
// - clk_i         in   1           clock; all logic on its rising edge.
// - rst_i         in   1           reset, asynchronous, active-high.
// - req_i         in   1           upstream request valid.
// - gnt_o         out  1           request accepted this cycle.
// - we_i          in   1           1 = write, 0 = read.
// - addr_i        in   AW          word address.
// - wdata_i       in   DATA_WIDTH  write data.
// - be_i          in   BE_W        byte enables; lane k = bits [8k+7:8k], top lane truncated.
// - rvalid_o      out  1           read data valid.
// - rdata_o       out  DATA_WIDTH  read data.
// - sram_req_o    out  1           SRAM chip enable.
// - sram_we_o     out  1           SRAM write enable.
// - sram_addr_o   out  AW          SRAM address.
// - sram_wdata_o  out  DATA_WIDTH  SRAM write data (full word).
// - sram_rdata_i  in   DATA_WIDTH  SRAM read data; 1-cycle latency after a read request.
// - rmw_cnt_o     out  32          RMW counter; see CONFIGURATION.
// BEHAVIOUR
// - States: S_IDLE, S_RMW_RD, S_RMW_WR. Reset state: S_IDLE.
// - Reset values: rvalid_o=0, rmw_cnt_o=0; internal addr/data/be buffers = 0.
// - Reset mid-RMW: sequence aborted; no SRAM write issued; state returns to S_IDLE.
// - gnt_o = req_i && state==S_IDLE. It is combinational and is never asserted outside S_IDLE.
// - In S_IDLE with req_i high, the request is decoded as follows:
//   - Read: sram_req_o=1, sram_we_o=0 same cycle; rvalid_o=1 next cycle; rdata_o=sram_rdata_i.
//     Back-to-back reads sustain one per cycle.
//   - Write, be_i all ones: single SRAM write same cycle; wdata passes through; no rvalid.
//   - Write, be_i==0: granted, no SRAM access, no state change.
//   - Partial write: SRAM read of addr_i issued at T; addr/wdata/be captured; go to S_RMW_RD.
// - S_RMW_RD (T+1):
//   - merged = be ? wdata : sram_rdata_i, applied per lane; merged is registered.
//   - sram_req_o=0; go to S_RMW_WR.
// - S_RMW_WR (T+2): SRAM write of the merged word to the captured address; return to S_IDLE.
// - Next grant is possible at T+3.
// - RMW read data never raises rvalid_o.
// - rdata_o is combinational from sram_rdata_i. It is don't-care when rvalid_o=0.
// - sram_* outputs are 0 whenever no access is issued.
// CONFIGURATION
// - SRAM_RMW_STATS_EN defined:
//   - rmw_cnt_o increments by 1 on every entry to S_RMW_WR.
//   - Saturates at 32'hFFFF_FFFF.
//   - Cleared by rst_i.
// - SRAM_RMW_STATS_EN undefined: counter logic removed; rmw_cnt_o tied to 32'h0. Port list is identical.
// TESTING
// 1. Reset: assert rst_i mid-cycle with req_i=1 -> rvalid_o=0 and sram_req_o=0 immediately; gnt_o=0 until rst_i drops.
// 2. Full write addr 5, data 64'h1122334455667788, be 8'hFF -> gnt_o and one sram write in the same cycle;
//    read addr 5 -> rvalid_o next cycle, rdata_o=64'h1122334455667788.
// 3. Partial write addr 5, data 64'hAAAAAAAA_BBBBBBBB, be 8'h0F over stored 64'h1122334455667788:
//    - SRAM read at T; SRAM write 64'h11223344_BBBBBBBB at T+2.
//    - gnt_o low at T+1 and T+2 even with req_i held high.
//    - Readback returns 64'h11223344_BBBBBBBB; no rvalid_o during the RMW.
// 4. Write with be 8'h00 -> gnt_o=1, sram_req_o=0, stored word unchanged.
// 5. Reads addr 0..3 on four consecutive cycles -> rvalid_o high four consecutive cycles, data in order.
// 6. rst_i pulsed in S_RMW_RD -> no SRAM write; old data readable;
//    with SRAM_RMW_STATS_EN, 3 completed RMWs -> rmw_cnt_o=3; without the macro rmw_cnt_o=0.

Source files
------------

// File: rtl/sram_rmw_ctrl.sv
// Read-modify-write sequencer in front of a cache SRAM macro that has no byte enables.
// Optional build macro SRAM_RMW_STATS_EN enables the saturating RMW counter on rmw_cnt_o.
module sram_rmw_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_i,
  output logic                         gnt_o,
  input  logic                         we_i,
  input  logic [$clog2(NUM_WORDS)-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  input  logic [(DATA_WIDTH+7)/8-1:0]  be_i,
  output logic                         rvalid_o,
  output logic [DATA_WIDTH-1:0]        rdata_o,
  output logic                         sram_req_o,
  output logic                         sram_we_o,
  output logic [$clog2(NUM_WORDS)-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0]        sram_wdata_o,
  input  logic [DATA_WIDTH-1:0]        sram_rdata_i,
  output logic [31:0]                  rmw_cnt_o
);

  localparam int AW   = $clog2(NUM_WORDS);
  localparam int BE_W = (DATA_WIDTH + 7) / 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RMW_RD = 2'd1,
    S_RMW_WR = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  rvalid_q;
  logic [AW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_W-1:0]       be_q;
  logic [DATA_WIDTH-1:0] merged_q;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] merged;

  logic                  gnt_raw;
  logic                  acc_req;
  logic                  acc_we;
  logic [AW-1:0]         acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  read_issue;
  logic                  capture;

  // Expand byte enables to a bit mask; the top lane may be narrower than 8 bits.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_mask
    assign lane_mask[i] = be_q[i/8];
  end

  assign merged = (wdata_q & lane_mask) | (sram_rdata_i & ~lane_mask);

  always_comb begin
    state_d    = state_q;
    gnt_raw    = 1'b0;
    acc_req    = 1'b0;
    acc_we     = 1'b0;
    acc_addr   = '0;
    acc_wdata  = '0;
    read_issue = 1'b0;
    capture    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          gnt_raw = 1'b1;
          if (!we_i) begin
            acc_req    = 1'b1;
            acc_addr   = addr_i;
            read_issue = 1'b1;
          end else if (be_i == {BE_W{1'b1}}) begin
            acc_req   = 1'b1;
            acc_we    = 1'b1;
            acc_addr  = addr_i;
            acc_wdata = wdata_i;
          end else if (be_i != '0) begin
            acc_req  = 1'b1;
            acc_addr = addr_i;
            capture  = 1'b1;
            state_d  = S_RMW_RD;
          end
        end
      end
      S_RMW_RD: state_d = S_RMW_WR;
      S_RMW_WR: begin
        acc_req   = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = addr_q;
        acc_wdata = merged_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      rvalid_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      merged_q <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= read_issue;
      if (capture) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        be_q    <= be_i;
      end
      if (state_q == S_RMW_RD) begin
        merged_q <= merged;
      end
    end
  end

  // Reset is an asynchronous abort, so it also silences the combinational outputs.
  assign gnt_o        = gnt_raw & ~rst_i;
  assign sram_req_o   = acc_req & ~rst_i;
  assign sram_we_o    = acc_we & ~rst_i;
  assign sram_addr_o  = rst_i ? '0 : acc_addr;
  assign sram_wdata_o = rst_i ? '0 : acc_wdata;
  assign rvalid_o     = rvalid_q;
  assign rdata_o      = sram_rdata_i;

`ifdef SRAM_RMW_STATS_EN
  logic [31:0] rmw_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rmw_cnt_q <= '0;
    end else if (state_q == S_RMW_RD && rmw_cnt_q != 32'hFFFF_FFFF) begin
      rmw_cnt_q <= rmw_cnt_q + 32'd1;
    end
  end

  assign rmw_cnt_o = rmw_cnt_q;
`else
  assign rmw_cnt_o = 32'h0;
`endif

endmodule
